// File: rtl/vdecoder.sv
// vdecoder: hard-decision Viterbi decoder for the rate-1/2, K=3 code (g0 = 111, g1 = 101).
// Serial code bits are paired (c0 first, then c1). Each pair drives one add-compare-select
// step over 4 states. The survivor memory is a fixed-depth register exchange.
//
// Parameters:
//   TB_DEPTH  survivor length in pairs (>= 4); also the decode latency in pairs
//   METRIC_W  path-metric width (>= 4); metrics saturate at 2^METRIC_W-1
// Ports:
//   Clock        rising-edge clock
//   reset        asynchronous active-high reset
//   in_valid     in carries a code bit this cycle
//   in           serial code bit
//   out_valid    one-cycle pulse, out holds a decoded bit
//   out          decoded data bit, held until the next pulse
//   best_metric  (only with VDEC_BEST_METRIC_EN defined) minimum path metric before
//                normalization from the latest ACS step
module vdecoder #(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned METRIC_W = 6
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in,
  output logic                out_valid,
  output logic                out
`ifdef VDEC_BEST_METRIC_EN
  ,
  output logic [METRIC_W-1:0] best_metric
`endif
);

  // Candidates need two extra bits: a saturated metric plus a branch metric of up to 2.
  localparam int unsigned CandW = METRIC_W + 2;
  localparam int unsigned CntW  = $clog2(TB_DEPTH + 1);
  // The oldest path bit is only ever consumed right after the update, so only the
  // TB_DEPTH-1 bits that survive the next shift are kept in registers.
  localparam int unsigned PathW = TB_DEPTH - 1;

  localparam logic [CntW-1:0]     CntMax = CntW'(TB_DEPTH);
  localparam logic [METRIC_W-1:0] PmMax  = {METRIC_W{1'b1}};
  localparam logic [METRIC_W-1:0] PmInit = {1'b1, {(METRIC_W - 1){1'b0}}};
  localparam logic [CandW-1:0]    SatMax = {2'b00, PmMax};

  logic                         phase_q, phase_d;
  logic                         c0_q, c0_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [3:0][METRIC_W-1:0]     pm_q, pm_d;
  logic [3:0][PathW-1:0]        path_q, path_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_q, out_d;

  logic                         step;
  logic [3:0][CandW-1:0]        acs_pm;
  logic [3:0][TB_DEPTH-1:0]     acs_path;
  logic [CandW-1:0]             min_pm;
  logic [3:0][METRIC_W-1:0]     norm_pm;
  logic [1:0]                   best_idx;

  // Hamming distance between the received pair and the pair expected when input u
  // leaves state {s1, s0}.
  function automatic logic [1:0] branch_metric(logic u, logic s1, logic s0,
                                               logic r0, logic r1);
    return {1'b0, u ^ s1 ^ s0 ^ r0} + {1'b0, u ^ s0 ^ r1};
  endfunction

  assign step = in_valid & phase_q;

  // Next state {n1, n0} is reached with u = n1 from predecessors {n0, s0}, s0 in {0, 1}.
  always_comb begin : acs
    logic [1:0]       ns;
    logic [1:0]       p0;
    logic [1:0]       p1;
    logic [CandW-1:0] cand0;
    logic [CandW-1:0] cand1;
    acs_pm   = '0;
    acs_path = '0;
    ns       = '0;
    p0       = '0;
    p1       = '0;
    cand0    = '0;
    cand1    = '0;
    for (int i = 0; i < 4; i++) begin
      ns    = 2'(i);
      p0    = {ns[0], 1'b0};
      p1    = {ns[0], 1'b1};
      cand0 = CandW'(pm_q[p0]) + CandW'(branch_metric(ns[1], ns[0], 1'b0, c0_q, in));
      cand1 = CandW'(pm_q[p1]) + CandW'(branch_metric(ns[1], ns[0], 1'b1, c0_q, in));
      // Strict compare: a tie keeps the predecessor with s0 = 0.
      if (cand1 < cand0) begin
        acs_pm[i]   = cand1;
        acs_path[i] = {path_q[p1], ns[1]};
      end else begin
        acs_pm[i]   = cand0;
        acs_path[i] = {path_q[p0], ns[1]};
      end
    end
  end

  always_comb begin : norm
    logic [CandW-1:0] diff;
    diff    = '0;
    norm_pm = '0;
    min_pm  = acs_pm[0];
    for (int i = 1; i < 4; i++) begin
      if (acs_pm[i] < min_pm) min_pm = acs_pm[i];
    end
    for (int i = 0; i < 4; i++) begin
      diff       = acs_pm[i] - min_pm;
      norm_pm[i] = (diff > SatMax) ? PmMax : diff[METRIC_W-1:0];
    end
    // Strict compare: ties go to the lowest state index.
    best_idx = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (norm_pm[i] < norm_pm[best_idx]) best_idx = 2'(i);
    end
  end

  always_comb begin : next_state
    phase_d     = phase_q;
    c0_d        = c0_q;
    cnt_d       = cnt_q;
    pm_d        = pm_q;
    path_d      = path_q;
    out_valid_d = 1'b0;
    out_d       = out_q;
    if (in_valid) begin
      phase_d = ~phase_q;
      if (!phase_q) c0_d = in;
    end
    if (step) begin
      pm_d = norm_pm;
      for (int i = 0; i < 4; i++) begin
        path_d[i] = acs_path[i][PathW-1:0];
      end
      if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
      if (cnt_d == CntMax) begin
        out_valid_d = 1'b1;
        out_d       = acs_path[best_idx][TB_DEPTH-1];
      end
    end
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      phase_q     <= 1'b0;
      c0_q        <= 1'b0;
      cnt_q       <= '0;
      // Encoder assumed to start in state 0.
      pm_q        <= {PmInit, PmInit, PmInit, {METRIC_W{1'b0}}};
      path_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      c0_q        <= c0_d;
      cnt_q       <= cnt_d;
      pm_q        <= pm_d;
      path_q      <= path_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

`ifdef VDEC_BEST_METRIC_EN
  logic [METRIC_W-1:0] best_metric_q, best_metric_d;

  // Some state always sits at 0 after normalization, so the raw minimum is at most 2.
  always_comb begin : best_metric_next
    best_metric_d = best_metric_q;
    if (step) best_metric_d = min_pm[METRIC_W-1:0];
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      best_metric_q <= '0;
    end else begin
      best_metric_q <= best_metric_d;
    end
  end

  assign best_metric = best_metric_q;
`endif

endmodule

// File: tb/tb_vdecoder.sv
module tb_vdecoder;

  localparam int TbDepth = 16;
  localparam int HistLen = 1024;

  logic Clock    = 1'b0;
  logic reset    = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit   = 1'b0;
  logic ov_a, o_a, ov_b, o_b;
`ifdef VDEC_BEST_METRIC_EN
  logic [5:0] bm_a;
  logic [3:0] bm_b;
`endif

  always #5 Clock = ~Clock;

  vdecoder #(.TB_DEPTH(TbDepth), .METRIC_W(6)) dut_a (
    .Clock      (Clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in         (in_bit),
    .out_valid  (ov_a),
    .out        (o_a)
`ifdef VDEC_BEST_METRIC_EN
    ,
    .best_metric(bm_a)
`endif
  );

  vdecoder #(.TB_DEPTH(TbDepth), .METRIC_W(4)) dut_b (
    .Clock      (Clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in         (in_bit),
    .out_valid  (ov_b),
    .out        (o_b)
`ifdef VDEC_BEST_METRIC_EN
    ,
    .best_metric(bm_b)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int first_tick = -1;
  int t0      = 0;
  int enc_s   = 0;

  // Reference model: full-history Viterbi per metric width (index 0: W=6, 1: W=4).
  int wid [2] = '{6, 4};
  int pm_m [2][4];
  int k_m [2];
  bit hist [2][4][HistLen];
  bit nh [4][HistLen];
  bit exp_v [2];
  bit exp_o [2];
  int exp_bm [2];
  bit ph;
  bit r0_m;

  bit obs_a [$];
  bit obs_b [$];
  bit dat [$];

  task automatic check_eq(string tag, int obs, int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      k_m[m]     = 0;
      pm_m[m][0] = 0;
      for (int s = 1; s < 4; s++) pm_m[m][s] = 1 << (wid[m] - 1);
      exp_v[m]  = 1'b0;
      exp_o[m]  = 1'b0;
      exp_bm[m] = 0;
    end
    ph   = 1'b0;
    r0_m = 1'b0;
    obs_a.delete();
    obs_b.delete();
    first_tick = -1;
  endtask

  task automatic model_pair(int m, bit r0, bit r1);
    int np [4];
    int pr [4];
    int bmin, best, k, maxv, c, u, s1, pred, d;
    maxv = (1 << wid[m]) - 1;
    for (int ns = 0; ns < 4; ns++) begin
      u  = ns >> 1;
      s1 = ns & 1;
      for (int s0 = 0; s0 < 2; s0++) begin
        pred = s1 * 2 + s0;
        d = ((((u ^ s1 ^ s0) & 1) != int'(r0)) ? 1 : 0) + ((((u ^ s0) & 1) != int'(r1)) ? 1 : 0);
        c = pm_m[m][pred] + d;
        if (s0 == 0 || c < np[ns]) begin
          np[ns] = c;
          pr[ns] = pred;
        end
      end
    end
    bmin = np[0];
    for (int s = 1; s < 4; s++) if (np[s] < bmin) bmin = np[s];
    k = k_m[m];
    if (k >= HistLen - 1) begin
      $display("FAIL model_history: got %0d pairs limit %0d", k, HistLen - 1);
      $fatal(1, "model history overflow");
    end
    for (int ns = 0; ns < 4; ns++) begin
      for (int i = 0; i < k; i++) nh[ns][i] = hist[m][pr[ns]][i];
      nh[ns][k] = ((ns >> 1) != 0);
    end
    for (int ns = 0; ns < 4; ns++) begin
      for (int i = 0; i <= k; i++) hist[m][ns][i] = nh[ns][i];
      pm_m[m][ns] = (np[ns] - bmin > maxv) ? maxv : np[ns] - bmin;
    end
    k_m[m] = k + 1;
    best = 0;
    for (int s = 1; s < 4; s++) if (pm_m[m][s] < pm_m[m][best]) best = s;
    exp_bm[m] = bmin;
    exp_v[m]  = (k_m[m] >= TbDepth);
    if (exp_v[m]) exp_o[m] = hist[m][best][k_m[m] - TbDepth];
  endtask

  // Sample outputs on the falling edge, then drive the next input and advance the model.
  task automatic tick(bit v, bit b);
    @(negedge Clock);
    cyc++;
    check_eq("out_valid_w6", int'(ov_a), int'(exp_v[0]));
    check_eq("out_w6", int'(o_a), int'(exp_o[0]));
    check_eq("out_valid_w4", int'(ov_b), int'(exp_v[1]));
    check_eq("out_w4", int'(o_b), int'(exp_o[1]));
`ifdef VDEC_BEST_METRIC_EN
    check_eq("best_metric_w6", int'(bm_a), exp_bm[0]);
    check_eq("best_metric_w4", int'(bm_b), exp_bm[1]);
`endif
    if (ov_a === 1'b1) begin
      obs_a.push_back(o_a);
      if (first_tick < 0) first_tick = cyc;
    end
    if (ov_b === 1'b1) obs_b.push_back(o_b);
    in_valid = v;
    in_bit   = b;
    exp_v[0] = 1'b0;
    exp_v[1] = 1'b0;
    if (v) begin
      if (!ph) begin
        r0_m = b;
        ph   = 1'b1;
      end else begin
        ph = 1'b0;
        model_pair(0, r0_m, b);
        model_pair(1, r0_m, b);
      end
    end
  endtask

  task automatic check_zero_outputs(string tag);
    check_eq({tag, "_out_valid_w6"}, int'(ov_a), 0);
    check_eq({tag, "_out_w6"}, int'(o_a), 0);
    check_eq({tag, "_out_valid_w4"}, int'(ov_b), 0);
    check_eq({tag, "_out_w4"}, int'(o_b), 0);
`ifdef VDEC_BEST_METRIC_EN
    check_eq({tag, "_best_metric_w6"}, int'(bm_a), 0);
    check_eq({tag, "_best_metric_w4"}, int'(bm_b), 0);
`endif
  endtask

  task automatic hard_reset();
    @(negedge Clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    #3;
    check_zero_outputs("reset");
    @(negedge Clock);
    reset = 1'b0;
    model_reset();
    enc_s = 0;
    dat.delete();
  endtask

  // Reset pulse placed between clock edges.
  task automatic async_reset_mid();
    tick(1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 check_zero_outputs("arst");
    #1 reset = 1'b0;
    model_reset();
    enc_s = 0;
    dat.delete();
  endtask

  task automatic encode(int u, output bit c0, output bit c1);
    int s1, s0;
    s1    = (enc_s >> 1) & 1;
    s0    = enc_s & 1;
    c0    = (((u ^ s1 ^ s0) & 1) != 0);
    c1    = (((u ^ s0) & 1) != 0);
    enc_s = ((u & 1) << 1) | s1;
  endtask

  task automatic send_pair(bit c0, bit c1, int gm, int ga);
    tick(1'b1, c0);
    repeat (gm) tick(1'b0, 1'($urandom));
    tick(1'b1, c1);
    repeat (ga) tick(1'b0, 1'($urandom));
  endtask

  // Sends 1,0,1,1 then 16 zero bits; optionally flips c0 of pair 2.
  task automatic send_known(bit flip, int gm, int ga);
    bit c0, c1;
    int d [4] = '{1, 0, 1, 1};
    for (int i = 0; i < 20; i++) begin
      int u;
      u = (i < 4) ? d[i] : 0;
      dat.push_back(u != 0);
      encode(u, c0, c1);
      if (flip && i == 1) c0 = ~c0;
      send_pair(c0, c1, gm, ga);
    end
    repeat (3) tick(1'b0, 1'b0);
  endtask

  task automatic check_decoded(string tag, int n_exp);
    check_eq({tag, "_count_w6"}, obs_a.size(), n_exp);
    check_eq({tag, "_count_w4"}, obs_b.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (i < obs_a.size()) check_eq({tag, "_bit_w6"}, int'(obs_a[i]), int'(dat[i]));
      if (i < obs_b.size()) check_eq({tag, "_bit_w4"}, int'(obs_b[i]), int'(dat[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit c0, c1;
    model_reset();
    repeat (2) @(negedge Clock);
    check_zero_outputs("por");
    reset = 1'b0;

    // Error-free decode, back-to-back, with latency check.
    hard_reset();
    t0 = cyc + 1;
    send_known(1'b0, 0, 0);
    check_eq("latency_first_pulse", first_tick - t0, 32);
    check_decoded("clean", 5);

    // Single-bit error in c0 of pair 2.
    hard_reset();
    send_known(1'b1, 0, 0);
    check_decoded("corrected", 5);

    // Idle gaps mid-pair and between pairs.
    hard_reset();
    send_known(1'b0, 3, 5);
    check_decoded("gaps", 5);

    // Reset after a lone c0, then a fresh random decode.
    hard_reset();
    tick(1'b1, 1'b1);
    async_reset_mid();
    for (int i = 0; i < 39; i++) begin
      int u;
      u = (i < 24) ? int'($urandom_range(0, 1)) : 0;
      dat.push_back(u != 0);
      encode(u, c0, c1);
      send_pair(c0, c1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end
    repeat (3) tick(1'b0, 1'b0);
    check_decoded("post_reset", 24);

    // Random noise pairs, then a clean stream that must decode after the flush.
    hard_reset();
    for (int i = 0; i < 200; i++) begin
      send_pair(1'($urandom), 1'($urandom), 0, int'($urandom_range(0, 1)));
    end
    enc_s = 0;
    for (int i = 0; i < 64; i++) begin
      int u;
      u = int'($urandom_range(0, 1));
      dat.push_back(u != 0);
      encode(u, c0, c1);
      send_pair(c0, c1, 0, 0);
    end
    repeat (3) tick(1'b0, 1'b0);
    check_eq("noisy_count_w6", obs_a.size(), 249);
    check_eq("noisy_count_w4", obs_b.size(), 249);
    for (int j = 17; j <= 49; j++) begin
      if (199 + j < obs_a.size()) check_eq("flushed_bit_w6", int'(obs_a[199 + j]),
                                           int'(dat[j - 1]));
      if (199 + j < obs_b.size()) check_eq("flushed_bit_w4", int'(obs_b[199 + j]),
                                           int'(dat[j - 1]));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
